// File: rtl/example_apb_regs.sv
// example_apb_regs
// APB slave with nine 32-bit read/write registers (word indices 0..8),
// a configurable number of wait states, byte strobes, a flat register image
// output and a one-cycle write strobe per register.
//
// Optional build macro: EXAMPLE_APB_REGS_PSLVERR_EN
//   defined   -> pslverr=1 in the completion cycle of any unmapped access
//   undefined -> pslverr is tied to 0; unmapped accesses complete silently

module example_apb_regs #(
    parameter int WAIT_STATES = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         psel,
    input  logic         penable,
    input  logic         pwrite,
    input  logic [31:0]  paddr,
    input  logic [31:0]  pwdata,
    input  logic [3:0]   pstrb,
    output logic [31:0]  prdata,
    output logic         pready,
    output logic         pslverr,
    output logic [287:0] regs_o,
    output logic [8:0]   wr_pulse
);

    localparam int NUM_REGS = 9;

    // Wait counter start value; the counter is 2 bits wide (WAIT_STATES 0..3).
    localparam logic [1:0] WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Address decode: upper bits must be zero and the word index in 0..8.
    function automatic logic is_hit(input logic [31:0] addr);
        return (addr[31:6] == 26'd0) && (addr[5:2] < 4'(NUM_REGS));
    endfunction

    // Register values after reset (reg5/reg6 are never reset).
    function automatic logic [31:0] reset_value(input int n);
        case (n)
            1, 2, 3: return 32'h0000_0001;
            4:       return 32'h0000_000C;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) result[8*b +: 8] = new_val[8*b +: 8];
        end
        return result;
    endfunction

    // ------------------------------------------------------------------
    // State and captured transfer attributes
    // ------------------------------------------------------------------
    state_t                       state;
    logic [1:0]                   wait_cnt;
    logic [3:0]                   idx_q;
    logic                         hit_q;
    logic                         write_q;
    logic [31:0]                  wdata_q;
    logic [3:0]                   strb_q;
    logic [NUM_REGS-1:0][31:0]    reg_vals;

    logic        start;
    logic        live_hit;
    logic        enter_resp;
    logic        resp_hit;
    logic        resp_write;
    logic [31:0] resp_rdata;
    logic        commit;
    logic        unused_addr_bits;

    // Byte offset within a word has no meaning for this block.
    assign unused_addr_bits = ^paddr[1:0];

    assign start    = (state == S_IDLE) && psel && penable;
    assign live_hit = is_hit(paddr);

    // The RESP cycle is entered either straight from IDLE (no wait states)
    // or from WAIT once the counter has expired and psel is still held.
    assign enter_resp = (start && (WAIT_STATES == 0)) ||
                        ((state == S_WAIT) && psel && (wait_cnt == 2'd0));

    // Write commits on the RESP->IDLE edge, so the new value and the strobe
    // both become visible in the cycle after RESP.
    assign commit = (state == S_RESP) && write_q && hit_q;

    // Select the attributes of the transfer about to enter RESP: live bus
    // values when coming straight from IDLE, captured values otherwise.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        resp_hit   = hit_q;
        resp_write = write_q;
        resp_rdata = '0;
        if (state == S_IDLE) begin
            resp_hit   = live_hit;
            resp_write = pwrite;
            if (live_hit) resp_rdata = reg_vals[paddr[5:2]];
        end else if (hit_q) begin
            resp_rdata = reg_vals[idx_q];
        end
    end

    // Transfer FSM with registered pready/prdata and write strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            pready   <= 1'b0;
            prdata   <= '0;
            wr_pulse <= '0;
            idx_q    <= '0;
            hit_q    <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            pready   <= 1'b0;
            prdata   <= '0;
            wr_pulse <= '0;

            if (enter_resp) begin
                pready <= 1'b1;
                prdata <= resp_write ? 32'd0 : resp_rdata;
            end

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        idx_q   <= paddr[5:2];
                        hit_q   <= live_hit;
                        write_q <= pwrite;
                        wdata_q <= pwdata;
                        strb_q  <= pstrb;
                        if (WAIT_STATES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (!psel) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == 2'd0) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    if (commit) wr_pulse <= 9'd1 << idx_q;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------
    for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
        logic        wr_en;
        logic [31:0] q;

        assign wr_en       = commit && (idx_q == 4'(n));
        assign reg_vals[n] = q;

        if (n == 5 || n == 6) begin : g_noreset
            // Storage-only register; contents are undefined until first written.
            // NOTE: leaving storage without reset is deliberate; only control state must be reset.
            always_ff @(posedge clk) begin
                if (wr_en) q <= merge_bytes(q, wdata_q, strb_q);
            end
        end else begin : g_withreset
            // Register with a defined reset value.
            always_ff @(posedge clk) begin
                if (reset) begin
                    q <= reset_value(n);
                end else if (wr_en) begin
                    q <= merge_bytes(q, wdata_q, strb_q);
                end
            end
        end
    end

    assign regs_o = reg_vals;

    // ------------------------------------------------------------------
    // Error response
    // ------------------------------------------------------------------
`ifdef EXAMPLE_APB_REGS_PSLVERR_EN
    // Flag unmapped accesses in their completion cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pslverr <= 1'b0;
        end else begin
            pslverr <= enter_resp && !resp_hit;
        end
    end
`else
    assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_example_apb_regs.sv
// Testbench for example_apb_regs: three instances (WAIT_STATES 0, 1, 3)
// exercised with directed vectors, hand-written corner sequences and
// randomized transfers checked against an array-based register model.
`timescale 1ns/1ps

module tb_example_apb_regs;

    localparam int NDUT = 3;
    localparam logic [31:0] RESET_VALS [9] = '{32'h0, 32'h1, 32'h1, 32'h1, 32'hC,
                                               32'h0, 32'h0, 32'h0, 32'h0};

    logic         clk = 1'b0;
    logic         reset;
    logic         psel    [NDUT];
    logic         penable [NDUT];
    logic         pwrite  [NDUT];
    logic [31:0]  paddr   [NDUT];
    logic [31:0]  pwdata  [NDUT];
    logic [3:0]   pstrb   [NDUT];
    logic [31:0]  prdata  [NDUT];
    logic         pready  [NDUT];
    logic         pslverr [NDUT];
    logic [287:0] regs_o  [NDUT];
    logic [8:0]   wr_pulse[NDUT];

    always #5 clk = ~clk;

    example_apb_regs #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .prdata(prdata[0]),
        .pready(pready[0]), .pslverr(pslverr[0]), .regs_o(regs_o[0]), .wr_pulse(wr_pulse[0]));
    example_apb_regs #(.WAIT_STATES(1)) u_dut1 (
        .clk(clk), .reset(reset), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .prdata(prdata[1]),
        .pready(pready[1]), .pslverr(pslverr[1]), .regs_o(regs_o[1]), .wr_pulse(wr_pulse[1]));
    example_apb_regs #(.WAIT_STATES(3)) u_dut2 (
        .clk(clk), .reset(reset), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
        .paddr(paddr[2]), .pwdata(pwdata[2]), .pstrb(pstrb[2]), .prdata(prdata[2]),
        .pready(pready[2]), .pslverr(pslverr[2]), .regs_o(regs_o[2]), .wr_pulse(wr_pulse[2]));

    // ------------------------------------------------------------------
    // Reference model: plain register array plus "value known" flags
    // ------------------------------------------------------------------
    logic [31:0] mreg      [NDUT][9];
    bit          mknown    [NDUT][9];
    logic [8:0]  exp_pulse [NDUT];

    int checks = 0;
    int errors = 0;

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    // Mapped iff the byte address lies below word 9 (0x24) with nothing above.
    function automatic bit mapped(input logic [31:0] addr);
        return addr < 32'h24;
    endfunction

    function automatic logic exp_err(input logic [31:0] addr);
`ifdef EXAMPLE_APB_REGS_PSLVERR_EN
        return !mapped(addr);
`else
        return 1'b0 & addr[0];
`endif
    endfunction

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < 9; n++) begin
                mreg[d][n]   = RESET_VALS[n];
                mknown[d][n] = !(n == 5 || n == 6);
            end
            exp_pulse[d] = '0;
        end
    endtask

    task automatic model_write(input int d, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb);
        int n;
        logic [31:0] mask;
        n = int'(addr >> 2);
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        mreg[d][n] = (mreg[d][n] & ~mask) | (wdata & mask);
        if (strb == 4'hF) mknown[d][n] = 1'b1;
        exp_pulse[d] = 9'(1) << n;
    endtask

    task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Checks made in the cycle after a completion (or any idle cycle).
    task automatic check_post(input int d);
        logic [287:0] img, mask;
        string tag;
        tag = $sformatf("dut%0d post", d);
        for (int n = 0; n < 9; n++) begin
            img[32*n +: 32]  = mreg[d][n];
            mask[32*n +: 32] = mknown[d][n] ? 32'hFFFF_FFFF : 32'h0;
        end
        check({tag, " pready"},   288'(pready[d]), 288'(0));
        check({tag, " prdata"},   288'(prdata[d]), 288'(0));
        check({tag, " wr_pulse"}, 288'(wr_pulse[d]), 288'(exp_pulse[d]));
        check({tag, " regs_o"},   regs_o[d] & mask, img & mask);
        exp_pulse[d] = '0;
    endtask

    task automatic flush(input int d);
        @(posedge clk); #1;
        check_post(d);
    endtask

    // Setup phase (or direct access when back-to-back), then enter ACCESS.
    task automatic start_xfer(input int d, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] strb, input bit b2b);
        @(negedge clk);
        psel[d]    = 1'b1;
        penable[d] = b2b;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wdata;
        pstrb[d]   = strb;
        @(posedge clk); #1;
        check_post(d);
        if (!b2b) begin
            @(negedge clk);
            penable[d] = 1'b1;
        end
    endtask

    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input bit b2b, input bit scramble,
                        input bit chk_rd, input logic [31:0] exp_rd);
        int lat;
        bit done;
        logic [31:0] rd;
        logic err;
        string tag;
        tag = $sformatf("dut%0d %s a=%h", d, wr ? "wr" : "rd", addr);
        rd = '0;
        err = 1'b0;
        start_xfer(d, wr, addr, wdata, strb, b2b);
        lat = 0;
        done = 1'b0;
        while (!done && lat < 12) begin
            @(posedge clk); #1;
            lat++;
            if (pready[d]) begin
                done = 1'b1;
                rd   = prdata[d];
                err  = pslverr[d];
            end else if (scramble) begin
                paddr[d]  = $urandom;
                pwdata[d] = $urandom;
                pstrb[d]  = 4'($urandom);
                pwrite[d] = 1'($urandom);
            end
        end
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        check({tag, " latency"}, 288'(lat), 288'(ws_of(d) + 1));
        if (done) begin
            check({tag, " pslverr"}, 288'(err), 288'(exp_err(addr)));
            if (!wr && chk_rd) check({tag, " prdata"}, 288'(rd), 288'(exp_rd));
            if (wr && mapped(addr)) model_write(d, addr, wdata, strb);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          chk;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input bit chk, input logic [31:0] exp_rd);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.chk = chk; v.exp_rd = exp_rd;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
        end
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("dut%0d reset pslverr", d), 288'(pslverr[d]), 288'(0));
            check_post(d);
        end
        @(negedge clk);
        reset = 1'b0;

        // Table: reads of all indices, full/partial writes, unmapped, pstrb=0
        for (int n = 0; n < 9; n++) add(1'b0, 32'(n * 4), 32'h0, 4'h0, !(n == 5 || n == 6), RESET_VALS[n]);
        add(1'b1, 32'h14, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
        add(1'b0, 32'h14, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF);
        add(1'b1, 32'h04, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0);
        add(1'b0, 32'h04, 32'h0, 4'h0, 1'b1, 32'h00BB_00DD);
        add(1'b0, 32'h28, 32'h0, 4'h0, 1'b1, 32'h0);
        add(1'b1, 32'h3C, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0);
        add(1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0);
        add(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0);
        add(1'b0, 32'h00, 32'h0, 4'h0, 1'b1, 32'h0);
        add(1'b0, 32'h3C, 32'h0, 4'h0, 1'b1, 32'h0);
        add(1'b1, 32'h20, 32'h1111_1111, 4'h0, 1'b0, 32'h0);
        add(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h0);
        add(1'b0, 32'h24, 32'h0, 4'h0, 1'b1, 32'h0);
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < vecs.size(); i++) begin
                xfer(d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                     (i % 2) == 1, 1'b0, vecs[i].chk, vecs[i].exp_rd);
            end
            flush(d);
        end

        // Abort by dropping psel during WAIT
        for (int d = 1; d < NDUT; d++) begin
            start_xfer(d, 1'b1, 32'h00, 32'h1234_5678, 4'hF, 1'b0);
            @(posedge clk); #1;
            check($sformatf("dut%0d abort pready early", d), 288'(pready[d]), 288'(0));
            @(negedge clk);
            psel[d] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                check($sformatf("dut%0d abort pready %0d", d, k), 288'(pready[d]), 288'(0));
                check($sformatf("dut%0d abort wr_pulse %0d", d, k), 288'(wr_pulse[d]), 288'(0));
            end
            penable[d] = 1'b0;
            xfer(d, 1'b0, 32'h00, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, mreg[d][0]);
            flush(d);
        end

        // Back-to-back writes to reg7/reg8 followed by back-to-back reads
        for (int d = 0; d < NDUT; d++) begin
            xfer(d, 1'b1, 32'h1C, 32'hA5A5_0007, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
            xfer(d, 1'b1, 32'h20, 32'h5A5A_0008, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0);
            xfer(d, 1'b0, 32'h1C, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'hA5A5_0007);
            xfer(d, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'h5A5A_0008);
            flush(d);
        end

        // Bus changes during WAIT must not affect the captured transfer
        for (int d = 1; d < NDUT; d++) begin
            xfer(d, 1'b1, 32'h08, 32'h1357_9BDF, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0);
            xfer(d, 1'b0, 32'h08, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1, 32'h1357_9BDF);
            flush(d);
        end

        // Reset during a pending write on the 3-wait-state instance
        start_xfer(2, 1'b1, 32'h1C, 32'hFEED_FACE, 4'hF, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        psel[2] = 1'b0;
        penable[2] = 1'b0;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("dut2 reset-abort pready %0d", k), 288'(pready[2]), 288'(0));
            check($sformatf("dut2 reset-abort wr_pulse %0d", k), 288'(wr_pulse[2]), 288'(0));
        end
        for (int d = 0; d < NDUT; d++) check_post(d);
        xfer(2, 1'b0, 32'h1C, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        flush(2);

        // Randomized transfers against the model
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 80; i++) begin
                logic [31:0] addr;
                logic [31:0] exp_rd;
                bit wr, chk, b2b;
                int sel;
                sel = $urandom_range(0, 9);
                if (sel < 8)       addr = 32'($urandom_range(0, 8) * 4);
                else if (sel == 8) addr = 32'($urandom_range(9, 15) * 4);
                else               addr = ($urandom & 32'hFFFF_FFC0) | (32'h40 << $urandom_range(0, 25))
                                          | 32'($urandom_range(0, 15) * 4);
                addr = addr | 32'($urandom_range(0, 3));
                wr  = 1'($urandom);
                b2b = (i > 0) && ($urandom_range(0, 1) == 1);
                if (mapped(addr)) begin
                    chk    = mknown[d][int'(addr >> 2)];
                    exp_rd = mreg[d][int'(addr >> 2)];
                end else begin
                    chk    = 1'b1;
                    exp_rd = 32'h0;
                end
                xfer(d, wr, addr, $urandom, 4'($urandom), b2b,
                     $urandom_range(0, 3) == 0, chk, exp_rd);
            end
            flush(d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/example_apb_regs.md
EXAMPLE_APB_REGS -- requirements
Module: example_apb_regs

Interface
REQ-001 Parameter WAIT_STATES, default 1, number of ACCESS cycles with pready low before completion (legal 0..3).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 psel  input  1  APB select.
REQ-005 penable  input  1  APB enable (ACCESS phase).
REQ-006 pwrite  input  1  1 = write, 0 = read.
REQ-007 paddr  input  32  byte address; word index = paddr[5:2], paddr[31:6] must be zero for a hit.
REQ-008 pwdata  input  32  write data.
REQ-009 pstrb  input  4  byte enables; bit i qualifies pwdata[8i+7:8i].
REQ-010 prdata  output  32  read data, valid when pready=1.
REQ-011 pready  output  1  transfer completion.
REQ-012 pslverr  output  1  error response, valid when pready=1.
REQ-013 regs_o  output  288  register image; register N at bits [32N+31:32N], N=0..8.
REQ-014 wr_pulse  output  9  one-cycle strobe per register, set in the cycle after a write commits.

Function
REQ-015 Register map: reg0..reg8 at word indices 0..8, each 32 bits, read/write; indices 9..15 or nonzero paddr[31:6] are unmapped.
REQ-016 FSM states IDLE, WAIT, RESP; IDLE->WAIT on psel&penable when WAIT_STATES>0, IDLE->RESP on psel&penable when WAIT_STATES=0.
REQ-017 WAIT holds a down-counter loaded with WAIT_STATES-1 on entry; WAIT->RESP when counter is 0, else decrement.
REQ-018 In RESP: pready=1 for exactly one cycle, then ->IDLE; pready=0 in all other states.
REQ-019 Address, pwrite, pwdata and pstrb are captured on IDLE exit; later bus changes during the transfer are ignored.
REQ-020 Write commits in the RESP cycle: for each set pstrb bit, the byte of the addressed register is updated; pstrb=0 leaves the register unchanged but still completes.
REQ-021 Write to an unmapped address: no register changes, wr_pulse stays 0.
REQ-022 wr_pulse[N]=1 in the cycle after RESP for a mapped write to reg N (including pstrb=0); 0 otherwise.
REQ-023 Read: prdata = addressed register in RESP cycle; prdata = 0 for unmapped reads and whenever pready=0.
REQ-024 regs_o reflects the new register value in the cycle after the RESP cycle.
REQ-025 psel deasserted during WAIT aborts: FSM ->IDLE next cycle, no commit, no pready.
REQ-026 Back-to-back: a new psel&penable seen in the cycle after RESP starts a new transfer; total per-transfer latency is WAIT_STATES+1 cycles of ACCESS.

Reset
REQ-027 On reset: FSM=IDLE, counter=0, pready=0, pslverr=0, prdata=0, wr_pulse=0.
REQ-028 Reset values: reg0=0x00000000, reg1=0x00000001, reg2=0x00000001, reg3=0x00000001, reg4=0x0000000C, reg7=0x00000000, reg8=0x00000000.
REQ-029 reg5 and reg6 have no reset; their contents are undefined until first written.
REQ-030 Reset asserted mid-transfer wins: the pending write is discarded and no pready is issued.

Configuration
REQ-031 Macro EXAMPLE_APB_REGS_PSLVERR_EN: when defined, pslverr=1 in the RESP cycle of any unmapped access, else 0.
REQ-032 Without EXAMPLE_APB_REGS_PSLVERR_EN, pslverr is constant 0 and unmapped accesses complete silently (reads return 0).

Verification
REQ-033 Reset, read all nine indices -> 0,1,1,1,0x0C,X,X,0,0; pslverr=0; pready after WAIT_STATES+1 ACCESS cycles.
REQ-034 Write reg5 0xDEADBEEF pstrb=0xF, read back -> 0xDEADBEEF; wr_pulse[5] one cycle; regs_o[191:160]=0xDEADBEEF.
REQ-035 Write reg1 0xAABBCCDD pstrb=0x5 over 0x00000001 -> reg1 reads 0x00BB00DD.
REQ-036 Read paddr=0x28 -> prdata=0, pslverr=1 with macro, 0 without; write paddr=0x3C changes no register.
REQ-037 Drop psel in WAIT during write of reg0=0x12345678 -> no pready, reg0 stays 0, wr_pulse=0.
REQ-038 WAIT_STATES=0 and 3 builds: back-to-back writes reg7/reg8 -> pready at ACCESS cycle 1 and 4 respectively, both values read back.
